// File: rtl/wb_arb_pkg.sv
// Shared definitions for the 3-master Wishbone round-robin arbiter.
//   arb_state_t : arbiter FSM states
//   OWNER_NONE  : owner encoding meaning "no master holds the bus"
//   *_W         : per-master Wishbone field widths
package wb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        FLUSH = 2'd2
    } arb_state_t;

    localparam logic [1:0] OWNER_NONE = 2'd3;
    localparam int         NUM_M      = 3;

    localparam int ADR_W = 32;
    localparam int DAT_W = 32;
    localparam int SEL_W = 4;
    localparam int CTI_W = 3;

endpackage

// File: rtl/wb_rr_pick.sv
// Combinational round-robin picker for three requesters.
// Ports:
//   req   [2:0] request vector, bit n = master n
//   last  [1:0] previous owner; search starts at last+1 (mod 3)
//   valid       at least one request present
//   idx   [1:0] chosen master index (0 when valid is low)
module wb_rr_pick (
    input  logic [2:0] req,
    input  logic [1:0] last,
    output logic       valid,
    output logic [1:0] idx
);

    always_comb begin
        valid = |req;
        idx   = 2'd0;
        case (last)
            2'd0: begin
                if      (req[1]) idx = 2'd1;
                else if (req[2]) idx = 2'd2;
                else if (req[0]) idx = 2'd0;
            end
            2'd1: begin
                if      (req[2]) idx = 2'd2;
                else if (req[0]) idx = 2'd0;
                else if (req[1]) idx = 2'd1;
            end
            // last == 2, or the unused code 3: master 0 has top priority
            default: begin
                if      (req[0]) idx = 2'd0;
                else if (req[1]) idx = 2'd1;
                else if (req[2]) idx = 2'd2;
            end
        endcase
    end

endmodule

// File: rtl/wb_rr_arbiter.sv
// 3-master Wishbone round-robin arbiter with a per-transfer ack timeout.
// One slave port is shared by masters 0..2. A slave that never answers a
// strobe is cut off after TIMEOUT strobe cycles: the owner gets err, the
// bus goes idle until that owner drops cyc, then arbitration resumes.
// Ports:
//   clock_i, reset_n_i         clock, synchronous active-low reset
//   adr_i/dat_i/sel_i/cti_i    master request fields, packed {m2,m1,m0}
//   we_i/cyc_i/stb_i           per-master control, bit n = master n
//   mdat_o, ack_o, err_o       master-side responses (ack/err owner-only)
//   sadr_o..sstb_o             slave-side request, driven only in GRANT
//   sdat_i, sack_i, serr_i     slave responses
//   owner_o                    current owner, 3 = none
//   timeout_o                  one-cycle pulse on a forced timeout
module wb_rr_arbiter
    import wb_arb_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic         clock_i,
    input  logic         reset_n_i,
    input  logic [95:0]  adr_i,
    input  logic [95:0]  dat_i,
    input  logic [11:0]  sel_i,
    input  logic [8:0]   cti_i,
    input  logic [2:0]   we_i,
    input  logic [2:0]   cyc_i,
    input  logic [2:0]   stb_i,
    output logic [31:0]  mdat_o,
    output logic [2:0]   ack_o,
    output logic [2:0]   err_o,
    output logic [31:0]  sadr_o,
    output logic [31:0]  sdat_o,
    output logic [3:0]   ssel_o,
    output logic [2:0]   scti_o,
    output logic         swe_o,
    output logic         scyc_o,
    output logic         sstb_o,
    input  logic [31:0]  sdat_i,
    input  logic         sack_i,
    input  logic         serr_i,
    output logic [1:0]   owner_o,
    output logic         timeout_o
);

    // A zero-width counter is illegal, so TIMEOUT=0 keeps a 1-bit counter
    // that is simply never compared.
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] TERM_CNT = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

    arb_state_t       r_state;
    logic [1:0]       r_owner;
    logic [1:0]       r_last;
    logic [CNT_W-1:0] r_cnt;

    logic             w_pick_vld;
    logic [1:0]       w_pick_idx;

    logic [ADR_W-1:0] w_adr;
    logic [DAT_W-1:0] w_dat;
    logic [SEL_W-1:0] w_sel;
    logic [CTI_W-1:0] w_cti;
    logic             w_we;
    logic             w_own_cyc;
    logic             w_own_stb;
    logic [2:0]       w_own_oh;

    logic             w_gnt;
    logic             w_sstb;
    logic             w_resp;
    logic             w_tmo;

    wb_rr_pick u_pick (
        .req   (cyc_i),
        .last  (r_last),
        .valid (w_pick_vld),
        .idx   (w_pick_idx)
    );

    // Owner-selected master fields. Owner code 3 selects nothing.
    always_comb begin
        w_adr     = '0;
        w_dat     = '0;
        w_sel     = '0;
        w_cti     = '0;
        w_we      = 1'b0;
        w_own_cyc = 1'b0;
        w_own_stb = 1'b0;
        w_own_oh  = 3'b000;
        case (r_owner)
            2'd0: begin
                w_adr     = adr_i[31:0];
                w_dat     = dat_i[31:0];
                w_sel     = sel_i[3:0];
                w_cti     = cti_i[2:0];
                w_we      = we_i[0];
                w_own_cyc = cyc_i[0];
                w_own_stb = stb_i[0];
                w_own_oh  = 3'b001;
            end
            2'd1: begin
                w_adr     = adr_i[63:32];
                w_dat     = dat_i[63:32];
                w_sel     = sel_i[7:4];
                w_cti     = cti_i[5:3];
                w_we      = we_i[1];
                w_own_cyc = cyc_i[1];
                w_own_stb = stb_i[1];
                w_own_oh  = 3'b010;
            end
            2'd2: begin
                w_adr     = adr_i[95:64];
                w_dat     = dat_i[95:64];
                w_sel     = sel_i[11:8];
                w_cti     = cti_i[8:6];
                w_we      = we_i[2];
                w_own_cyc = cyc_i[2];
                w_own_stb = stb_i[2];
                w_own_oh  = 3'b100;
            end
            default: ;
        endcase
    end

    assign w_gnt  = (r_state == GRANT);
    // A strobe without cyc from the owner is not a valid bus cycle.
    assign w_sstb = w_gnt & w_own_stb & w_own_cyc;
    assign w_resp = sack_i | serr_i;
    // A slave response on the terminal cycle takes precedence over the timeout.
    assign w_tmo  = (TIMEOUT > 0) && w_sstb && !w_resp && (r_cnt == TERM_CNT);

    assign sadr_o    = w_gnt ? w_adr : '0;
    assign sdat_o    = w_gnt ? w_dat : '0;
    assign ssel_o    = w_gnt ? w_sel : '0;
    assign scti_o    = w_gnt ? w_cti : '0;
    assign swe_o     = w_gnt & w_we;
    assign scyc_o    = w_gnt;
    assign sstb_o    = w_sstb;
    assign mdat_o    = w_gnt ? sdat_i : '0;
    assign ack_o     = (w_gnt && sack_i) ? w_own_oh : 3'b000;
    assign err_o     = (w_gnt && (serr_i || w_tmo)) ? w_own_oh : 3'b000;
    assign timeout_o = w_tmo;
    assign owner_o   = r_owner;

    always_ff @(posedge clock_i) begin
        if (!reset_n_i) begin
            r_state <= IDLE;
            r_owner <= OWNER_NONE;
            r_last  <= 2'd2;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_pick_vld) begin
                        r_state <= GRANT;
                        r_owner <= w_pick_idx;
                        r_cnt   <= '0;
                    end
                end
                GRANT: begin
                    // Release always goes through IDLE, so grants are
                    // separated by at least one idle cycle.
                    if (!w_own_cyc) begin
                        r_state <= IDLE;
                        r_last  <= r_owner;
                        r_owner <= OWNER_NONE;
                    end else if (w_resp) begin
                        r_cnt <= '0;
                    end else if (w_tmo) begin
                        r_state <= FLUSH;
                        r_last  <= r_owner;
                        r_cnt   <= '0;
                    end else if (w_sstb) begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                FLUSH: begin
                    // Owner is kept only to watch its cyc; the bus stays idle.
                    if (!w_own_cyc) begin
                        r_state <= IDLE;
                        r_owner <= OWNER_NONE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_owner <= OWNER_NONE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
module tb_wb_rr_arbiter;

    logic        clock_i = 1'b0;
    logic        reset_n_i;
    logic [95:0] adr_i;
    logic [95:0] dat_i;
    logic [11:0] sel_i;
    logic [8:0]  cti_i;
    logic [2:0]  we_i;
    logic [2:0]  cyc_i;
    logic [2:0]  stb_i;
    logic [31:0] mdat_o;
    logic [2:0]  ack_o;
    logic [2:0]  err_o;
    logic [31:0] sadr_o;
    logic [31:0] sdat_o;
    logic [3:0]  ssel_o;
    logic [2:0]  scti_o;
    logic        swe_o;
    logic        scyc_o;
    logic        sstb_o;
    logic [31:0] sdat_i;
    logic        sack_i;
    logic        serr_i;
    logic [1:0]  owner_o;
    logic        timeout_o;

    int checks   = 0;
    int failures = 0;

    wb_rr_arbiter #(.TIMEOUT(4)) dut (
        .clock_i   (clock_i),
        .reset_n_i (reset_n_i),
        .adr_i     (adr_i),
        .dat_i     (dat_i),
        .sel_i     (sel_i),
        .cti_i     (cti_i),
        .we_i      (we_i),
        .cyc_i     (cyc_i),
        .stb_i     (stb_i),
        .mdat_o    (mdat_o),
        .ack_o     (ack_o),
        .err_o     (err_o),
        .sadr_o    (sadr_o),
        .sdat_o    (sdat_o),
        .ssel_o    (ssel_o),
        .scti_o    (scti_o),
        .swe_o     (swe_o),
        .scyc_o    (scyc_o),
        .sstb_o    (sstb_o),
        .sdat_i    (sdat_i),
        .sack_i    (sack_i),
        .serr_i    (serr_i),
        .owner_o   (owner_o),
        .timeout_o (timeout_o)
    );

    always #5 clock_i = ~clock_i;

    // Advance past the next rising edge; inputs are then changed safely.
    task automatic tick();
        @(posedge clock_i);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        // Distinct per-master fields; master 1 carries the routing vector.
        adr_i  = {32'h0000_2000, 32'h0000_1000, 32'h0000_0AA0};
        dat_i  = {32'h2222_2222, 32'hDEAD_BEEF, 32'h0000_0001};
        sel_i  = {4'h3, 4'hF, 4'h1};
        cti_i  = {3'd2, 3'd7, 3'd1};
        we_i   = 3'b010;
        cyc_i  = 3'b111;
        stb_i  = 3'b111;
        sdat_i = 32'hCAFE_0123;
        sack_i = 1'b1;
        serr_i = 1'b0;
        reset_n_i = 1'b0;

        // Reset held with all masters requesting and a stray slave ack
        tick(); tick(); tick();
        #1;
        chk("rst_owner", 32'(owner_o), 32'd3);
        chk("rst_scyc",  32'(scyc_o),  32'd0);
        chk("rst_ack",   32'(ack_o),   32'd0);
        chk("rst_err",   32'(err_o),   32'd0);
        chk("rst_tmo",   32'(timeout_o), 32'd0);
        reset_n_i = 1'b1;
        sack_i    = 1'b0;
        tick();
        #1;
        chk("first_owner", 32'(owner_o), 32'd0);

        // Master 0: one acked transfer, then drops cyc
        sack_i = 1'b1;
        #1;
        chk("m0_ack", 32'(ack_o), 32'b001);
        tick();
        sack_i = 1'b0;
        cyc_i  = 3'b110;
        tick();
        #1;
        chk("rr_idle0", 32'(owner_o), 32'd3);
        chk("rr_idle0_scyc", 32'(scyc_o), 32'd0);
        cyc_i = 3'b111;
        tick();
        #1;
        chk("rr_owner1", 32'(owner_o), 32'd1);

        // Routing from master 1
        chk("mux_adr",  sadr_o, 32'h0000_1000);
        chk("mux_dat",  sdat_o, 32'hDEAD_BEEF);
        chk("mux_sel",  32'(ssel_o), 32'hF);
        chk("mux_cti",  32'(scti_o), 32'd7);
        chk("mux_we",   32'(swe_o),  32'd1);
        chk("mux_scyc", 32'(scyc_o), 32'd1);
        chk("mux_sstb", 32'(sstb_o), 32'd1);
        sack_i = 1'b1;
        #1;
        chk("m1_ack",  32'(ack_o), 32'b010);
        chk("m1_err",  32'(err_o), 32'b000);
        chk("m1_mdat", mdat_o, 32'hCAFE_0123);
        tick();
        sack_i = 1'b0;
        cyc_i  = 3'b101;
        tick();
        #1;
        chk("rr_idle1", 32'(owner_o), 32'd3);
        cyc_i = 3'b111;
        tick();
        #1;
        chk("rr_owner2", 32'(owner_o), 32'd2);
        chk("m2_adr", sadr_o, 32'h0000_2000);
        chk("m2_we",  32'(swe_o), 32'd0);
        sack_i = 1'b1;
        #1;
        chk("m2_ack", 32'(ack_o), 32'b100);
        tick();
        sack_i = 1'b0;
        cyc_i  = 3'b011;
        tick();
        #1;
        chk("rr_idle2", 32'(owner_o), 32'd3);
        cyc_i = 3'b111;
        tick();
        #1;
        chk("rr_owner0", 32'(owner_o), 32'd0);
        sack_i = 1'b1;
        tick();
        sack_i = 1'b0;

        // Timeout: only master 2 requests; last owner 0 so 2 is picked
        cyc_i = 3'b100;
        tick();
        #1;
        chk("to_idle", 32'(owner_o), 32'd3);
        tick();
        #1;
        chk("to_owner2", 32'(owner_o), 32'd2);
        for (int i = 1; i <= 3; i++) begin
            chk($sformatf("to_pre%0d_tmo", i), 32'(timeout_o), 32'd0);
            chk($sformatf("to_pre%0d_err", i), 32'(err_o), 32'd0);
            tick();
            #1;
        end
        chk("to_err", 32'(err_o), 32'b100);
        chk("to_tmo", 32'(timeout_o), 32'd1);
        tick();
        sack_i = 1'b1;
        #1;
        chk("flush_scyc", 32'(scyc_o), 32'd0);
        chk("flush_sstb", 32'(sstb_o), 32'd0);
        chk("flush_ack",  32'(ack_o),  32'd0);
        chk("flush_tmo",  32'(timeout_o), 32'd0);
        tick();
        #1;
        chk("flush2_scyc", 32'(scyc_o), 32'd0);
        sack_i = 1'b0;
        cyc_i  = 3'b001;
        tick();
        #1;
        chk("flush_exit", 32'(owner_o), 32'd3);
        tick();
        #1;
        chk("after_to_owner0", 32'(owner_o), 32'd0);

        // Race: ack on the terminal cycle beats the timeout
        for (int i = 1; i <= 3; i++) begin
            tick();
        end
        sack_i = 1'b1;
        #1;
        chk("race_ack", 32'(ack_o), 32'b001);
        chk("race_err", 32'(err_o), 32'b000);
        chk("race_tmo", 32'(timeout_o), 32'd0);
        tick();
        sack_i = 1'b0;
        // Counter restarted: three quiet strobe cycles, then the timeout
        for (int i = 1; i <= 3; i++) begin
            #1;
            chk($sformatf("race_post%0d_tmo", i), 32'(timeout_o), 32'd0);
            tick();
        end
        #1;
        chk("race_recount_tmo", 32'(timeout_o), 32'd1);
        chk("race_recount_err", 32'(err_o), 32'b001);

        // Mid-transfer reset while master 1 owns the bus
        cyc_i = 3'b010;
        tick();
        tick();
        tick();
        #1;
        chk("mid_owner1", 32'(owner_o), 32'd1);
        chk("mid_sstb",   32'(sstb_o),  32'd1);
        cyc_i     = 3'b111;
        reset_n_i = 1'b0;
        tick();
        #1;
        chk("mid_rst_scyc",  32'(scyc_o),  32'd0);
        chk("mid_rst_owner", 32'(owner_o), 32'd3);
        chk("mid_rst_ack",   32'(ack_o),   32'd0);
        reset_n_i = 1'b1;
        tick();
        #1;
        chk("mid_rst_first", 32'(owner_o), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wb_rr_arbiter.md
Name: wb_rr_arbiter

Overview:
- 3-master Wishbone arbiter with round-robin fairness and a per-transfer ack timeout; it shares one Wishbone slave bus between masters 0..2.
- It sits between the CPU/DMA/display masters and the memory controller port.
- A hung slave cannot lock the bus: the stalled owner receives an error, the bus is released, and arbitration resumes.

Parameters:
TIMEOUT, 64, cycles of strobe-without-ack before forced error; 0 disables timeout
CNT_W, $clog2(TIMEOUT+1), timeout counter width (derived, not overridden)

Ports:
clock_i  input  1  system clock, all logic on rising edge
reset_n_i  input  1  synchronous reset, active-low
adr_i  input  96  master addresses packed {m2,m1,m0}, 32b each
dat_i  input  96  master write data packed {m2,m1,m0}
sel_i  input  12  byte selects packed, 4b each
cti_i  input  9  cycle type packed, 3b each
we_i  input  3  write enables, bit n = master n
cyc_i  input  3  cycle requests
stb_i  input  3  strobes
mdat_o  output  32  read data broadcast to all masters
ack_o  output  3  ack, only owner's bit can be high
err_o  output  3  error, only owner's bit can be high
sadr_o  output  32  slave address
sdat_o  output  32  slave write data
ssel_o  output  4  slave byte selects
scti_o  output  3  slave cycle type
swe_o  output  1  slave write enable
scyc_o  output  1  slave cycle
sstb_o  output  1  slave strobe
sdat_i  input  32  slave read data
sack_i  input  1  slave ack
serr_i  input  1  slave error
owner_o  output  2  current owner 0..2; 3 = none
timeout_o  output  1  one-cycle pulse on forced timeout

Behaviour:
- Clock clock_i; reset reset_n_i is synchronous and active-low. Reset: state IDLE, owner_o=3, last_owner=2 (master 0 wins first), counter=0. All outputs 0 except owner_o.
- Reset asserted mid-transfer drops the grant at that edge. No ack or err is issued.
- States:
  - IDLE: no owner.
  - GRANT: owner drives bus.
  - FLUSH: timed-out owner still holding cyc.
- IDLE -> GRANT when any cyc_i is high:
  - Pick the first requester in order last_owner+1, +2, +3 (mod 3).
  - Register it as owner; owner is visible the cycle after cyc_i rises (1-cycle grant latency).
- GRANT:
  - sadr_o/sdat_o/ssel_o/scti_o/swe_o are muxed from owner; scyc_o=1; sstb_o=stb_i[owner].
  - ack_o[owner]=sack_i, err_o[owner]=serr_i, combinationally. Other bits are 0.
  - In IDLE and FLUSH, slave-side outputs are 0.
- GRANT -> IDLE when cyc_i[owner]=0; last_owner:=owner.
  - At least one IDLE cycle between grants. No same-edge handover.
- Timeout counter:
  - Clears on entry to GRANT and on any cycle with sack_i|serr_i.
  - Increments each GRANT cycle with sstb_o=1 and no sack_i/serr_i.
  - Holds when sstb_o=0.
- At count==TIMEOUT-1 with no ack (TIMEOUT>0):
  - That cycle: err_o[owner]=1 and timeout_o=1.
  - Next state: FLUSH, or IDLE if cyc_i[owner] is already 0.
  - last_owner:=owner.
- FLUSH: bus idle, slave responses ignored. FLUSH -> IDLE when cyc_i[owner]=0.
- Simultaneous sack_i with the timeout terminal cycle: ack wins, counter clears, no error.
- cyc_i dropped by a non-owner has no effect. A master's stb without cyc is ignored.
- Slave error passes through as a normal termination; no state change.

Decomposition:
- Package wb_arb_pkg holds:
  - state enum {IDLE, GRANT, FLUSH};
  - OWNER_NONE=2'd3;
  - per-master field widths (ADR_W=32, DAT_W=32, SEL_W=4, CTI_W=3).
- Sub-module wb_rr_pick is purely combinational: inputs req[2:0] and last[1:0]; outputs valid and idx[1:0]. It is instantiated once.
- The FSM, counter and muxes live in wb_rr_arbiter.

Test Plan:
- Reset: hold reset_n_i=0 with cyc_i=3'b111 -> owner_o=3, scyc_o=0, ack_o=err_o=0. Release; the cycle after, owner_o=0.
- Round-robin: all three masters hold cyc, each drops after one acked transfer -> grant order 0,1,2,0 with one IDLE cycle between grants.
- Mux/routing: master 1 writes adr=0x0000_1000, dat=0xDEADBEEF, sel=4'hF -> slave sees the same values and swe_o=1. sack_i -> ack_o=3'b010 only.
- Timeout: TIMEOUT=4, master 2 strobes, sack_i held 0 -> err_o=3'b100 and timeout_o=1 on the 4th strobe cycle. Bus idle while cyc_i[2] is held; grant goes to master 0 when it requests after release.
- Race: TIMEOUT=4, sack_i=1 exactly on the 4th strobe cycle -> ack_o set, err_o=0, timeout_o=0, counter back to 0.
- Mid-transfer reset: assert reset_n_i during a GRANT with stb high -> next cycle scyc_o=0, owner_o=3. After release, master 0 is granted first.
